id_ex_stage_register: RTL and testbench
=======================================

# id_ex_stage_register

Pipeline register between the decode stage (control-signal decoder plus register-file read) and the execute stage. Captures the decoded control bundle and operand data each cycle and presents them registered to the ALU, memory and writeback paths. Detects load-use hazards and inserts bubbles. Supports external stall and branch flush, and keeps a saturating count of inserted bubbles.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC width
- REG_ADDR_WIDTH, 4, register specifier width
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- stall  input  1  hold all EX-side state
- flush  input  1  replace next EX contents with bubble (branch taken)
- id_valid  input  1  decode slot holds a real instruction
- id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select, id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size  input  1 each  decoded control bits
- id_alu_operation  input  4  decoded ALU op
- id_cond  input  4  instruction[31:28]
- id_rn_addr, id_rm_addr, id_rd_addr  input  REG_ADDR_WIDTH  source/destination specifiers
- id_rn_data, id_rm_data, id_imm, id_pc  input  DATA_WIDTH  operands, extended immediate, PC
- flag_n, flag_z, flag_c, flag_v  input  1 each  current status flags (used only with ID_EX_COND_EVAL_EN)
- ex_* (one per id_ control/data input above, except the rn/rm addresses)  output  same width  registered copies
- ex_valid  output  1  EX slot holds a real instruction
- hazard_stall  output  1  combinational; upstream must hold PC and IF/ID this cycle
- bubble_count  output  CNT_WIDTH  saturating count of bubbles inserted by hazard

## Operation
- Bubble = ex_valid=0. All eight ex_ control bits are 0, and ex_alu_operation=4'b0000. Data outputs are don't-care but are driven 0.
- Load-use hazard: hazard_stall=1 iff all of the following hold:
  - ex_valid is 1.
  - ex_mem_enable=1, ex_mem_rw=0 and ex_reg_write_enable=1.
  - id_valid is 1.
  - ex_rd_addr equals id_rn_addr or id_rm_addr. Rm is compared only when id_alu_source_select=0.
- hazard_stall is forced 0 while stall or flush is high.
- Per-edge priority:
  1. reset: bubble, bubble_count=0.
  2. flush: bubble. This also applies when stall is high.
  3. stall: hold all outputs.
  4. hazard_stall: bubble, bubble_count+1, saturating at all-ones.
  5. otherwise: load the ex_ outputs from the id_ inputs, with ex_valid=id_valid. When id_valid=0, load a bubble.
- An all-zero instruction (NOP) arrives with all control bits 0 and is loaded as a valid no-op. It is never treated as a hazard source, because ex_mem_enable=0.
- Branches: ex_pc_source_select passes through. The branch resolver drives flush the cycle after, and this block does not self-flush.

## Timing
- Latency 1 cycle, ID to EX.
- Reset values: every ex_ output is 0, ex_valid=0, bubble_count=0, hazard_stall=0.
- hazard_stall is combinational from the ex_ registers and the id_ inputs, with no registered delay. A load followed by a dependent instruction costs exactly one bubble. The cycle after the bubble, hazard_stall deasserts because ex_valid=0.
- Back-to-back hazards, e.g. load→load-dependent→load-dependent: one bubble each. The counter increments once per bubble cycle.
- Counter at all-ones: stays at all-ones, with no wrap.
- Reset asserted mid-stall: reset wins on that edge.
- Flush and hazard in the same cycle: one bubble, counter unchanged.

## Configuration
- ID_EX_COND_EVAL_EN defined:
  - On a normal load (step 5), id_cond is evaluated against flag_n, flag_z, flag_c and flag_v using the ARM condition table (0000 EQ … 1110 AL; 1111 treated as never).
  - On failure a bubble is loaded. The counter is unchanged.
  - ex_cond still holds the captured code.
- ID_EX_COND_EVAL_EN undefined:
  - The flag inputs are ignored and every instruction is treated as passing.
  - ex_cond is still registered for downstream use.

## Test plan
- Reset: hold reset 2 cycles with random id_ inputs → all ex_ outputs 0, ex_valid=0, bubble_count=0.
- Passthrough: id_valid=1, ADD with id_alu_operation=4'b0000, id_rd_addr=3, id_rn_data=32'h5 → after 1 edge, ex_rd_addr=3, ex_rn_data=32'h5, ex_valid=1.
- Load-use: cycle 0 load LDR r2 (mem_enable=1, mem_rw=0, reg_write=1, rd=2); cycle 1 id_rn_addr=2.
  - Cycle 1: hazard_stall=1.
  - Cycle 2: ex_valid=0 and bubble_count=1.
  - Cycle 3: the dependent instruction appears in EX.
- Store is not a hazard: EX holds STR (mem_rw=1) with rd=2 and ID reads r2 → hazard_stall=0.
- Stall/flush: stall=1 for 3 cycles → EX outputs frozen. Then stall=1 together with flush=1 → next edge gives ex_valid=0.
- Condition, with the macro defined: id_cond=4'b0000 (EQ) and flag_z=0 → bubble; flag_z=1 → instruction loaded. Without the macro, both cases are loaded.

Source files
------------

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: captures the decoded control bundle and operands, inserts load-use bubbles.
// Latency: 1 cycle ID->EX; hazard_stall is combinational from the EX registers and ID inputs.
// Backpressure: stall holds EX state; flush overrides stall with a bubble. Optional macro ID_EX_COND_EVAL_EN.
module id_ex_stage_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic                      id_reg_write_enable,
    input  logic                      id_mem_enable,
    input  logic                      id_mem_rw,
    input  logic                      id_mem_to_reg_select,
    input  logic                      id_alu_source_select,
    input  logic                      id_status_bit,
    input  logic                      id_pc_source_select,
    input  logic                      id_mem_size,
    input  logic [3:0]                id_alu_operation,
    input  logic [3:0]                id_cond,
    input  logic [REG_ADDR_WIDTH-1:0] id_rn_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rm_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0]     id_rn_data,
    input  logic [DATA_WIDTH-1:0]     id_rm_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic                      flag_n,
    input  logic                      flag_z,
    input  logic                      flag_c,
    input  logic                      flag_v,
    output logic                      ex_valid,
    output logic                      ex_reg_write_enable,
    output logic                      ex_mem_enable,
    output logic                      ex_mem_rw,
    output logic                      ex_mem_to_reg_select,
    output logic                      ex_alu_source_select,
    output logic                      ex_status_bit,
    output logic                      ex_pc_source_select,
    output logic                      ex_mem_size,
    output logic [3:0]                ex_alu_operation,
    output logic [3:0]                ex_cond,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [DATA_WIDTH-1:0]     ex_rn_data,
    output logic [DATA_WIDTH-1:0]     ex_rm_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic                      hazard_stall,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    // Everything that travels ID->EX; an all-zero value is a bubble.
    typedef struct packed {
        logic                      valid;
        logic                      reg_write_enable;
        logic                      mem_enable;
        logic                      mem_rw;
        logic                      mem_to_reg_select;
        logic                      alu_source_select;
        logic                      status_bit;
        logic                      pc_source_select;
        logic                      mem_size;
        logic [3:0]                alu_operation;
        logic [3:0]                cond;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]     rn_data;
        logic [DATA_WIDTH-1:0]     rm_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc;
    } stage_t;

    stage_t                ex_q, ex_d, id_bundle;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cond_pass;
    logic                  ex_is_load;
    logic                  src_match;

    assign id_bundle = '{
        valid:             1'b1,
        reg_write_enable:  id_reg_write_enable,
        mem_enable:        id_mem_enable,
        mem_rw:            id_mem_rw,
        mem_to_reg_select: id_mem_to_reg_select,
        alu_source_select: id_alu_source_select,
        status_bit:        id_status_bit,
        pc_source_select:  id_pc_source_select,
        mem_size:          id_mem_size,
        alu_operation:     id_alu_operation,
        cond:              id_cond,
        rd_addr:           id_rd_addr,
        rn_data:           id_rn_data,
        rm_data:           id_rm_data,
        imm:               id_imm,
        pc:                id_pc
    };

`ifdef ID_EX_COND_EVAL_EN
    // ARM condition-code evaluation against the current flags; 1111 never executes.
    always_comb begin
        cond_pass = 1'b0;
        case (id_cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    // Flags are not consulted in this build; every instruction executes.
    logic unused_flags;
    assign unused_flags = ^{flag_n, flag_z, flag_c, flag_v};
    assign cond_pass    = 1'b1;
`endif

    // Load-use detection: a valid load in EX whose destination feeds a source read in ID.
    assign ex_is_load   = ex_q.valid && ex_q.mem_enable && !ex_q.mem_rw && ex_q.reg_write_enable;
    assign src_match    = (ex_q.rd_addr == id_rn_addr) ||
                          (!id_alu_source_select && (ex_q.rd_addr == id_rm_addr));
    assign hazard_stall = !stall && !flush && ex_is_load && id_valid && src_match;

    // Next-state selection in priority order: flush, stall, hazard bubble, normal load.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d  = '0;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else if (id_valid && cond_pass) begin
            ex_d = id_bundle;
        end else begin
            ex_d = '0;
        end
    end

    // EX-side state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid             = ex_q.valid;
    assign ex_reg_write_enable  = ex_q.reg_write_enable;
    assign ex_mem_enable        = ex_q.mem_enable;
    assign ex_mem_rw            = ex_q.mem_rw;
    assign ex_mem_to_reg_select = ex_q.mem_to_reg_select;
    assign ex_alu_source_select = ex_q.alu_source_select;
    assign ex_status_bit        = ex_q.status_bit;
    assign ex_pc_source_select  = ex_q.pc_source_select;
    assign ex_mem_size          = ex_q.mem_size;
    assign ex_alu_operation     = ex_q.alu_operation;
    assign ex_cond              = ex_q.cond;
    assign ex_rd_addr           = ex_q.rd_addr;
    assign ex_rn_data           = ex_q.rn_data;
    assign ex_rm_data           = ex_q.rm_data;
    assign ex_imm               = ex_q.imm;
    assign ex_pc                = ex_q.pc;
    assign bubble_count         = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Testbench for id_ex_stage_register: directed scenarios plus random traffic against a reference model.
// Latency: outputs checked on the falling edge after each rising edge; hazard checked before the edge.
// Backpressure: stall/flush/reset driven directly and randomly.
module tb_id_ex_stage_register;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall, flush, id_valid;
    logic          id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select;
    logic          id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size;
    logic [3:0]    id_alu_operation, id_cond;
    logic [AW-1:0] id_rn_addr, id_rm_addr, id_rd_addr;
    logic [DW-1:0] id_rn_data, id_rm_data, id_imm, id_pc;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          ex_valid, ex_reg_write_enable, ex_mem_enable, ex_mem_rw, ex_mem_to_reg_select;
    logic          ex_alu_source_select, ex_status_bit, ex_pc_source_select, ex_mem_size;
    logic [3:0]    ex_alu_operation, ex_cond;
    logic [AW-1:0] ex_rd_addr;
    logic [DW-1:0] ex_rn_data, ex_rm_data, ex_imm, ex_pc;
    logic          hazard_stall;
    logic [CW-1:0] bubble_count;

    int total = 0;
    int bad   = 0;

    // Reference model: what the EX slot should hold, as plain variables.
    logic          m_valid;
    logic [7:0]    m_ctrl;
    logic [3:0]    m_op, m_cond;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_rn, m_rm, m_imm, m_pc;
    int            m_cnt;

    always #5 clk = ~clk;

    id_ex_stage_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_reg_write_enable(id_reg_write_enable), .id_mem_enable(id_mem_enable),
        .id_mem_rw(id_mem_rw), .id_mem_to_reg_select(id_mem_to_reg_select),
        .id_alu_source_select(id_alu_source_select), .id_status_bit(id_status_bit),
        .id_pc_source_select(id_pc_source_select), .id_mem_size(id_mem_size),
        .id_alu_operation(id_alu_operation), .id_cond(id_cond),
        .id_rn_addr(id_rn_addr), .id_rm_addr(id_rm_addr), .id_rd_addr(id_rd_addr),
        .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm), .id_pc(id_pc),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .ex_valid(ex_valid), .ex_reg_write_enable(ex_reg_write_enable),
        .ex_mem_enable(ex_mem_enable), .ex_mem_rw(ex_mem_rw),
        .ex_mem_to_reg_select(ex_mem_to_reg_select), .ex_alu_source_select(ex_alu_source_select),
        .ex_status_bit(ex_status_bit), .ex_pc_source_select(ex_pc_source_select),
        .ex_mem_size(ex_mem_size), .ex_alu_operation(ex_alu_operation), .ex_cond(ex_cond),
        .ex_rd_addr(ex_rd_addr), .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] id_ctrl();
        return {id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select,
                id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size};
    endfunction

    // Does the instruction in ID read the destination of a load sitting in EX?
    function automatic logic model_hazard();
        logic ex_load, uses;
        if (stall || flush) return 1'b0;
        ex_load = m_valid && m_ctrl[7] && m_ctrl[6] && !m_ctrl[5];
        uses    = (m_rd == id_rn_addr) || (!id_alu_source_select && (m_rd == id_rm_addr));
        return ex_load && id_valid && uses;
    endfunction

    function automatic logic model_cond_ok();
`ifdef ID_EX_COND_EVAL_EN
        logic [15:0] pass;
        pass = {1'b0, 1'b1, flag_z | (flag_n ^ flag_v), !flag_z & !(flag_n ^ flag_v),
                flag_n ^ flag_v, !(flag_n ^ flag_v), !flag_c | flag_z, flag_c & !flag_z,
                !flag_v, flag_v, !flag_n, flag_n, !flag_c, flag_c, !flag_z, flag_z};
        return pass[id_cond];
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_op = '0; m_cond = '0; m_rd = '0;
        m_rn = '0; m_rm = '0; m_imm = '0; m_pc = '0;
    endfunction

    task automatic check_outputs();
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_ctrl", 64'({ex_reg_write_enable, ex_mem_enable, ex_mem_rw, ex_mem_to_reg_select,
                              ex_alu_source_select, ex_status_bit, ex_pc_source_select,
                              ex_mem_size}), 64'(m_ctrl));
        check("ex_alu_op", 64'(ex_alu_operation), 64'(m_op));
        check("ex_cond", 64'(ex_cond), 64'(m_cond));
        check("ex_rd", 64'(ex_rd_addr), 64'(m_rd));
        check("ex_rn_data", 64'(ex_rn_data), 64'(m_rn));
        check("ex_rm_data", 64'(ex_rm_data), 64'(m_rm));
        check("ex_imm", 64'(ex_imm), 64'(m_imm));
        check("ex_pc", 64'(ex_pc), 64'(m_pc));
        check("bubble_count", 64'(bubble_count), 64'(m_cnt));
    endtask

    // One clock: check the combinational hazard, advance the model on the edge, check the EX slot.
    task automatic cycle();
        logic h;
        #1;
        h = model_hazard();
        if (!reset) check("hazard_stall", 64'(hazard_stall), 64'(h));
        @(posedge clk);
        if (reset) begin
            model_clear(); m_cnt = 0;
        end else if (flush) begin
            model_clear();
        end else if (stall) begin
            // EX slot unchanged
        end else if (h) begin
            model_clear(); m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end else if (id_valid && model_cond_ok()) begin
            m_valid = 1'b1; m_ctrl = id_ctrl(); m_op = id_alu_operation; m_cond = id_cond;
            m_rd = id_rd_addr; m_rn = id_rn_data; m_rm = id_rm_data; m_imm = id_imm; m_pc = id_pc;
        end else begin
            model_clear();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_id();
        id_valid             = 1'($urandom_range(0, 3) != 0);
        id_reg_write_enable  = 1'($urandom_range(0, 1));
        id_mem_enable        = 1'($urandom_range(0, 1));
        id_mem_rw            = 1'($urandom_range(0, 1));
        id_mem_to_reg_select = 1'($urandom_range(0, 1));
        id_alu_source_select = 1'($urandom_range(0, 1));
        id_status_bit        = 1'($urandom_range(0, 1));
        id_pc_source_select  = 1'($urandom_range(0, 1));
        id_mem_size          = 1'($urandom_range(0, 1));
        id_alu_operation     = 4'($urandom_range(0, 15));
        id_cond              = 4'($urandom_range(0, 15));
        id_rn_addr           = AW'($urandom_range(0, 3));
        id_rm_addr           = AW'($urandom_range(0, 3));
        id_rd_addr           = AW'($urandom_range(0, 3));
        id_rn_data           = $urandom;
        id_rm_data           = $urandom;
        id_imm               = $urandom;
        id_pc                = $urandom;
        {flag_n, flag_z, flag_c, flag_v} = 4'($urandom_range(0, 15));
    endtask

    // Plain always-executing ALU instruction with all controls low.
    task automatic zero_id();
        id_valid = 1'b1;
        {id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select,
         id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size} = '0;
        id_alu_operation = 4'b0000; id_cond = 4'b1110;
        id_rn_addr = '0; id_rm_addr = '0; id_rd_addr = '0;
        id_rn_data = '0; id_rm_data = '0; id_imm = '0; id_pc = '0;
        {flag_n, flag_z, flag_c, flag_v} = 4'b0000;
    endtask

    task automatic set_load(input logic [AW-1:0] rd, input logic [AW-1:0] rn);
        zero_id();
        id_reg_write_enable = 1'b1; id_mem_enable = 1'b1; id_mem_rw = 1'b0;
        id_alu_source_select = 1'b1; id_rd_addr = rd; id_rn_addr = rn;
    endtask

    initial begin
        model_clear(); m_cnt = 0;
        stall = 1'b0; flush = 1'b0; reset = 1'b1;
        rand_id();

        // Reset held two cycles with random ID inputs.
        cycle(); rand_id(); cycle();
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_count", 64'(bubble_count), 64'd0);
        reset = 1'b0;

        // Passthrough of a simple ADD.
        zero_id(); id_rd_addr = 4'd3; id_rn_data = 32'h5; id_rn_addr = 4'd1;
        cycle();
        check("pt_rd", 64'(ex_rd_addr), 64'd3);
        check("pt_rn_data", 64'(ex_rn_data), 64'h5);
        check("pt_valid", 64'(ex_valid), 64'd1);

        // Load-use: LDR r2 then an instruction reading r2.
        set_load(4'd2, 4'd0); cycle();
        zero_id(); id_rn_addr = 4'd2; id_rd_addr = 4'd5; id_alu_source_select = 1'b1;
        #1 check("lu_hazard", 64'(hazard_stall), 64'd1);
        cycle();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_count", 64'(bubble_count), 64'd1);
        cycle();
        check("lu_dep_rd", 64'(ex_rd_addr), 64'd5);
        check("lu_dep_valid", 64'(ex_valid), 64'd1);

        // Store in EX with rd=2 is not a hazard source.
        zero_id(); id_mem_enable = 1'b1; id_mem_rw = 1'b1; id_rd_addr = 4'd2; cycle();
        zero_id(); id_rn_addr = 4'd2; id_rd_addr = 4'd7;
        #1 check("st_no_hazard", 64'(hazard_stall), 64'd0);
        cycle();

        // Stall three cycles with changing ID inputs: EX frozen.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_id(); cycle(); end
        check("stall_rd", 64'(ex_rd_addr), 64'd7);
        check("stall_valid", 64'(ex_valid), 64'd1);
        flush = 1'b1; cycle();
        check("flush_over_stall", 64'(ex_valid), 64'd0);
        stall = 1'b0; flush = 1'b0;

        // Flush and hazard together: bubble, counter unchanged.
        set_load(4'd2, 4'd0); cycle();
        zero_id(); id_rn_addr = 4'd2; flush = 1'b1; cycle();
        check("flush_hz_count", 64'(bubble_count), 64'd1);
        flush = 1'b0;

        // Condition EQ with Z clear, then Z set.
        zero_id(); id_cond = 4'b0000; id_rd_addr = 4'd9; flag_z = 1'b0; cycle();
`ifdef ID_EX_COND_EVAL_EN
        check("cond_eq_fail", 64'(ex_valid), 64'd0);
`else
        check("cond_eq_fail", 64'(ex_valid), 64'd1);
`endif
        flag_z = 1'b1; cycle();
        check("cond_eq_pass", 64'(ex_valid), 64'd1);
        check("cond_code", 64'(ex_cond), 64'd0);

        // Dependent load held in ID: a bubble every other cycle until the counter saturates.
        set_load(4'd2, 4'd2);
        for (int i = 0; i < 40; i++) cycle();
        check("sat_count", 64'(bubble_count), 64'(CMAX));

        // Reset during stall: reset wins.
        stall = 1'b1; reset = 1'b1; cycle();
        check("rst_stall_valid", 64'(ex_valid), 64'd0);
        check("rst_stall_count", 64'(bubble_count), 64'd0);
        stall = 1'b0; reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            stall = 1'($urandom_range(0, 9) == 0);
            flush = 1'($urandom_range(0, 9) == 0);
            reset = 1'($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
